// File: rtl/mem_responder.sv
// Wait-state memory responder for the CPU control-unit bus: byte RAM with a programmable access latency.
// Define MEM_IO_PORT_EN to add the ioOut register decoded at IO_ADDR.
module mem_responder #(
  parameter int          ADDR_BITS   = 12,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] IO_ADDR     = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addrBus,
  input  logic        rWMem,
  input  logic [7:0]  dBusOut,
  output logic [7:0]  dBusIn,
  output logic        memRdy
`ifdef MEM_IO_PORT_EN
  ,
  output logic [7:0]  ioOut
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LOAD_CNT = 4'(WAIT_CYCLES);
`ifdef MEM_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_addr;
  logic                  r_rw;
  logic [3:0]            r_cnt;
  logic [7:0]            r_io;
  logic [7:0]            r_mem [0:(1<<ADDR_BITS)-1];

  logic                  w_change;
  logic                  w_latch;
  logic                  w_dec;
  logic                  w_access;
  logic                  w_io_hit;
  logic [ADDR_BITS-1:0]  w_ram_addr;

  // Any difference in {address, direction} restarts the access from scratch.
  assign w_change   = (addrBus != r_addr) || (rWMem != r_rw);
  assign w_ram_addr = r_addr[ADDR_BITS-1:0];
  assign w_io_hit   = IO_EN && (r_addr == IO_ADDR);

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_dec       = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      IDLE: begin
        w_latch     = 1'b1;
        w_state_nxt = BUSY;
      end
      BUSY: begin
        if (w_change) begin
          w_latch = 1'b1;
        end else if (r_cnt != 4'd0) begin
          w_dec = 1'b1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (w_change) begin
          w_latch     = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= 16'h0000;
      r_rw    <= 1'b1;
      r_cnt   <= 4'd0;
      memRdy  <= 1'b0;
      dBusIn  <= 8'h00;
      r_io    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_addr <= addrBus;
        r_rw   <= rWMem;
        r_cnt  <= LOAD_CNT;
        memRdy <= 1'b0;
      end else if (w_dec) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        memRdy <= 1'b1;
        if (r_rw) begin
          dBusIn <= w_io_hit ? r_io : r_mem[w_ram_addr];
        end else if (w_io_hit) begin
          r_io <= dBusOut;
        end
      end
    end
  end

  // RAM contents survive reset; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && w_access && !r_rw && !w_io_hit) begin
      r_mem[w_ram_addr] <= dBusOut;
    end
  end

`ifdef MEM_IO_PORT_EN
  assign ioOut = r_io;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=1 instance plus a WAIT_CYCLES=0 instance sharing stimulus.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addrBus;
  logic        rWMem;
  logic [7:0]  dBusOut;
  logic [7:0]  dBusIn;
  logic        memRdy;
  logic [7:0]  dBusIn0;
  logic        memRdy0;
`ifdef MEM_IO_PORT_EN
  logic [7:0]  ioOut;
  logic [7:0]  ioOut0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(1), .IO_ADDR(16'hFF00)) dut (
    .clk(clk), .rst(rst), .addrBus(addrBus), .rWMem(rWMem), .dBusOut(dBusOut),
    .dBusIn(dBusIn), .memRdy(memRdy)
`ifdef MEM_IO_PORT_EN
    , .ioOut(ioOut)
`endif
  );

  mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(0), .IO_ADDR(16'hFF00)) dut_w0 (
    .clk(clk), .rst(rst), .addrBus(addrBus), .rWMem(rWMem), .dBusOut(dBusOut),
    .dBusIn(dBusIn0), .memRdy(memRdy0)
`ifdef MEM_IO_PORT_EN
    , .ioOut(ioOut0)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the WAIT_CYCLES=1 instance raises memRdy; -1 on timeout.
  task automatic wait_rdy(input int budget, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (!memRdy && edges < budget);
    if (!memRdy) edges = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; addrBus = 16'h0010; rWMem = 1'b1; dBusOut = 8'h00;
    tick(); tick();
    checks++; if (dBusIn !== 8'h00) begin errors++; $display("FAIL reset_dBusIn: got %h expected 00", dBusIn); end
    checks++; if (memRdy !== 1'b0) begin errors++; $display("FAIL reset_memRdy: got %b expected 0", memRdy); end
    checks++; if (memRdy0 !== 1'b0) begin errors++; $display("FAIL reset_memRdy_w0: got %b expected 0", memRdy0); end
`ifdef MEM_IO_PORT_EN
    checks++; if (ioOut !== 8'h00) begin errors++; $display("FAIL reset_ioOut: got %h expected 00", ioOut); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (memRdy !== 1'b0 || memRdy0 !== 1'b0) begin errors++; $display("FAIL reset_capture: got %b/%b expected 0/0", memRdy, memRdy0); end
    tick();
    checks++; if (memRdy0 !== 1'b1) begin errors++; $display("FAIL reset_lat_w0: got %b expected 1", memRdy0); end
    checks++; if (memRdy !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b expected 0", memRdy); end
    tick();
    checks++; if (memRdy !== 1'b1) begin errors++; $display("FAIL reset_lat: got %b expected 1", memRdy); end
  endtask

  task automatic test_write_read();
    int n;
    addrBus = 16'h0000; rWMem = 1'b0; dBusOut = 8'h03;
    wait_rdy(20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", n); end
    rWMem = 1'b1;
    tick();
    checks++; if (memRdy !== 1'b0) begin errors++; $display("FAIL rd_drop: got %b expected 0", memRdy); end
    wait_rdy(20, n);
    checks++; if (n !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", n); end
    checks++; if (dBusIn !== 8'h03) begin errors++; $display("FAIL rd_data: got %h expected 03", dBusIn); end
    checks++; if (dBusIn0 !== 8'h03) begin errors++; $display("FAIL rd_data_w0: got %h expected 03", dBusIn0); end
  endtask

  task automatic test_write_once();
    int n;
    addrBus = 16'h0020; rWMem = 1'b0; dBusOut = 8'h55;
    wait_rdy(20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL wonce_latency: got %0d expected 3", n); end
    checks++; if (dBusIn !== 8'h03) begin errors++; $display("FAIL wonce_dBusIn_held: got %h expected 03", dBusIn); end
    dBusOut = 8'h99;
    tick(); tick(); tick();
    checks++; if (memRdy !== 1'b1) begin errors++; $display("FAIL wonce_hold: got %b expected 1", memRdy); end
    rWMem = 1'b1;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'h55) begin errors++; $display("FAIL wonce_data: got %h expected 55", dBusIn); end
  endtask

  task automatic test_abort();
    int n;
    rWMem = 1'b0; dBusOut = 8'hAA;
    tick();
    checks++; if (memRdy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", memRdy); end
    addrBus = 16'h0021;
    wait_rdy(20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL abort_relatch_latency: got %0d expected 3", n); end
    addrBus = 16'h0020; rWMem = 1'b1;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'h55) begin errors++; $display("FAIL abort_untouched: got %h expected 55", dBusIn); end
    checks++; if (dBusIn0 !== 8'h55) begin errors++; $display("FAIL abort_untouched_w0: got %h expected 55", dBusIn0); end
    addrBus = 16'h0021;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'hAA) begin errors++; $display("FAIL abort_new_addr: got %h expected AA", dBusIn); end
  endtask

  task automatic test_mirror();
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) begin addrBus = 16'h1005; rWMem = 1'b0; dBusOut = 8'h5A; end
      else begin addrBus = 16'h0005; rWMem = 1'b1; dBusOut = 8'h00; end
      tick();
      checks++; if (memRdy !== 1'b0 || memRdy0 !== 1'b0) begin errors++; $display("FAIL mirror_capture%0d: got %b/%b expected 0/0", pass, memRdy, memRdy0); end
      tick();
      checks++; if (memRdy0 !== 1'b1 || memRdy !== 1'b0) begin errors++; $display("FAIL mirror_edge2_%0d: got %b/%b expected 0/1", pass, memRdy, memRdy0); end
      tick();
      checks++; if (memRdy !== 1'b1) begin errors++; $display("FAIL mirror_edge3_%0d: got %b expected 1", pass, memRdy); end
    end
    checks++; if (dBusIn !== 8'h5A) begin errors++; $display("FAIL mirror_data: got %h expected 5A", dBusIn); end
    checks++; if (dBusIn0 !== 8'h5A) begin errors++; $display("FAIL mirror_data_w0: got %h expected 5A", dBusIn0); end
  endtask

  task automatic test_reset_mid();
    int n;
    addrBus = 16'h0030; rWMem = 1'b0; dBusOut = 8'h11;
    wait_rdy(20, n);
    rWMem = 1'b1;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'h11) begin errors++; $display("FAIL rmid_prior: got %h expected 11", dBusIn); end
    rWMem = 1'b0; dBusOut = 8'h77;
    tick();
    checks++; if (memRdy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", memRdy); end
    rst = 1'b1;
    tick();
    checks++; if (memRdy !== 1'b0 || dBusIn !== 8'h00) begin errors++; $display("FAIL rmid_reset: got %b/%h expected 0/00", memRdy, dBusIn); end
    checks++; if (memRdy0 !== 1'b0 || dBusIn0 !== 8'h00) begin errors++; $display("FAIL rmid_reset_w0: got %b/%h expected 0/00", memRdy0, dBusIn0); end
    rst = 1'b0; rWMem = 1'b1;
    wait_rdy(20, n);
    checks++; if (n !== 3) begin errors++; $display("FAIL rmid_latency: got %0d expected 3", n); end
    checks++; if (dBusIn !== 8'h11) begin errors++; $display("FAIL rmid_dropped: got %h expected 11", dBusIn); end
    checks++; if (dBusIn0 !== 8'h11) begin errors++; $display("FAIL rmid_dropped_w0: got %h expected 11", dBusIn0); end
  endtask

`ifdef MEM_IO_PORT_EN
  task automatic test_io();
    int n;
    addrBus = 16'h0F00; rWMem = 1'b0; dBusOut = 8'h3C;
    wait_rdy(20, n);
    addrBus = 16'hFF00; dBusOut = 8'hC3;
    tick(); tick();
    checks++; if (ioOut !== 8'h00) begin errors++; $display("FAIL io_early: got %h expected 00", ioOut); end
    tick();
    checks++; if (memRdy !== 1'b1 || ioOut !== 8'hC3) begin errors++; $display("FAIL io_write: got %b/%h expected 1/C3", memRdy, ioOut); end
    rWMem = 1'b1;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'hC3) begin errors++; $display("FAIL io_read: got %h expected C3", dBusIn); end
    addrBus = 16'h0F00;
    wait_rdy(20, n);
    checks++; if (dBusIn !== 8'h3C) begin errors++; $display("FAIL io_ram_untouched: got %h expected 3C", dBusIn); end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_write_once();
    test_abort();
    test_mirror();
    test_reset_mid();
`ifdef MEM_IO_PORT_EN
    test_io();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
